// File: rtl/aes256_inv_key_sched_ctrl.sv
// Sequential AES-256 inverse key expansion: one shared inverse step iterated 7 times into a 15 x 128-bit round-key buffer.
// Optional AES_KEY_ZEROIZE_EN: flush/reset zero all key material and not-ready reads return 0.
module aes256_inv_key_sched_ctrl #(
    parameter int NUM_RK    = 15,
    parameter int NUM_STEPS = 7
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         start_i,
    input  logic [255:0] key_i,
    input  logic         flush_i,
    output logic         busy_o,
    output logic         ready_o,
    output logic         done_o,
    input  logic         rd_en_i,
    input  logic [3:0]   rd_idx_i,
    output logic [127:0] rd_data_o,
    output logic         rd_valid_o,
    output logic         rd_err_o
);

    localparam logic [1:0] ALG_AES256 = 2'b10;
    localparam logic [2:0] LAST_STEP  = 3'(NUM_STEPS);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[2047 - 8*int'(x) -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Window layout: [255:128] = w[b+4..b+7], [127:0] = w[b..b+3], b = 4 mod 8.
    // Each step recovers the previous eight words w[b-8..b-1] in the same layout.
    function automatic logic [255:0] inv_step(input logic [255:0] w, input logic [3:0] rnd,
                                              input logic [1:0] alg);
        logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7;
        logic [31:0] n1, n2, n3, n4, n5, n6, n7, n8;
        logic [7:0]  rcon;
        if (alg != ALG_AES256)
            return w;
        {w4, w5, w6, w7} = w[255:128];
        {w0, w1, w2, w3} = w[127:0];
        rcon = 8'h01 << (rnd - 4'd1);
        n1 = w7 ^ w6;
        n2 = w6 ^ w5;
        n3 = w5 ^ w4;
        n4 = w4 ^ sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h0};
        n5 = w3 ^ w2;
        n6 = w2 ^ w1;
        n7 = w1 ^ w0;
        n8 = w0 ^ sub_word(n1);
        return {n4, n3, n2, n1, n8, n7, n6, n5};
    endfunction

    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_e;

    state_e        state_q, state_d;
    logic [2:0]    step_q, step_d;
    logic          done_q, done_d;
    logic          load, advance;
    logic [255:0]  work_q, step_res;
    logic [3:0]    rnd;
    logic [127:0]  rk_q [NUM_RK];
    logic [NUM_RK-1:0] rk_we;
    logic [127:0]  rk_wd [NUM_RK];
    logic [127:0]  rk_rd;
    logic          rd_in_range;
    logic [127:0]  rd_data_q;
    logic          rd_valid_q, rd_err_q;

    assign rnd      = 4'd8 - {1'b0, step_q};
    assign step_res = inv_step(work_q, rnd, ALG_AES256);

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        done_d  = 1'b0;
        load    = 1'b0;
        advance = 1'b0;
        if (flush_i) begin
            state_d = IDLE;
            step_d  = '0;
        end else begin
            case (state_q)
                IDLE, READY: begin
                    if (start_i) begin
                        load    = 1'b1;
                        state_d = EXPAND;
                        step_d  = 3'd1;
                    end
                end
                EXPAND: begin
                    advance = 1'b1;
                    if (step_q == LAST_STEP) begin
                        state_d = READY;
                        done_d  = 1'b1;
                        step_d  = '0;
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            step_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            work_q <= '0;
        else if (load)
            work_q <= key_i;
        else if (advance)
            work_q <= step_res;
`ifdef AES_KEY_ZEROIZE_EN
        else if (flush_i)
            work_q <= '0;
`endif
    end

    // Step s fills entries 2s (upper half) and 2s+1 (lower half); the last step only has entry 14.
    always_comb begin
        for (int i = 0; i < NUM_RK; i++) begin
            rk_we[i] = 1'b0;
            rk_wd[i] = '0;
        end
        if (load) begin
            rk_we[0] = 1'b1;
            rk_wd[0] = key_i[255:128];
            rk_we[1] = 1'b1;
            rk_wd[1] = key_i[127:0];
        end
        for (int i = 2; i < NUM_RK; i++) begin
            if (advance && step_q == 3'(i / 2)) begin
                rk_we[i] = 1'b1;
                rk_wd[i] = ((i % 2) == 0) ? step_res[255:128] : step_res[127:0];
            end
        end
    end

`ifdef AES_KEY_ZEROIZE_EN
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_RK; i++) rk_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_RK; i++) begin
                if (flush_i)
                    rk_q[i] <= '0;
                else if (rk_we[i])
                    rk_q[i] <= rk_wd[i];
            end
        end
    end
`else
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_RK; i++) begin
            if (rk_we[i])
                rk_q[i] <= rk_wd[i];
        end
    end
`endif

    always_comb begin
        rk_rd = '0;
        for (int i = 0; i < NUM_RK; i++) begin
            if (rd_idx_i == 4'(i))
                rk_rd = rk_q[i];
        end
    end

    assign rd_in_range = rd_idx_i < 4'(NUM_RK);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else if (rd_en_i) begin
            rd_valid_q <= 1'b1;
            rd_err_q   <= !rd_in_range || !ready_o;
            if (!rd_in_range)
                rd_data_q <= '0;
`ifdef AES_KEY_ZEROIZE_EN
            else if (!ready_o)
                rd_data_q <= '0;
`endif
            else
                rd_data_q <= rk_rd;
        end else begin
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end
    end

    assign busy_o     = (state_q == EXPAND);
    assign ready_o    = (state_q == READY);
    assign done_o     = done_q;
    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign rd_err_o   = rd_err_q;

endmodule

// File: tb/tb_aes256_inv_key_sched_ctrl.sv
// Bench for aes256_inv_key_sched_ctrl using the FIPS-197 C.3 (key 00..1f) round keys.
module tb_aes256_inv_key_sched_ctrl;

`ifdef AES_KEY_ZEROIZE_EN
    localparam bit ZEROIZE = 1'b1;
`else
    localparam bit ZEROIZE = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [255:0] key = '0;
    logic         rd_en = 1'b0;
    logic [3:0]   rd_idx = '0;
    logic         busy, ready, done, rd_valid, rd_err;
    logic [127:0] rd_data;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic         err;
        logic [127:0] data;
        bit           chk;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Forward-schedule round keys 0..14; the buffer holds them in reverse order.
    logic [127:0] RK [15] = '{
        128'h000102030405060708090a0b0c0d0e0f, 128'h101112131415161718191a1b1c1d1e1f,
        128'ha573c29fa176c498a97fce93a572c09c, 128'h1651a8cd0244beda1a5da4c10640bade,
        128'hae87dff00ff11b68a68ed5fb03fc1567, 128'h6de1f1486fa54f9275f8eb5373b8518d,
        128'hc656827fc9a799176f294cec6cd5598b, 128'h3de23a75524775e727bf9eb45407cf39,
        128'h0bdc905fc27b0948ad5245a4c1871c2f, 128'h45f5a66017b2d387300d4d33640a820a,
        128'h7ccff71cbeb4fe5413e6bbf0d261a7df, 128'hf01afafee7a82979d7a5644ab3afe640,
        128'h2541fe719bf500258813bbd55a721c0a, 128'h4e5a6699a9f24fe07e572baacdf8cdea,
        128'h24fc79ccbf0979e9371ac23c6d68de36
    };

    aes256_inv_key_sched_ctrl dut (
        .clk_i      (clk),
        .reset_i    (rst),
        .start_i    (start),
        .key_i      (key),
        .flush_i    (flush),
        .busy_o     (busy),
        .ready_o    (ready),
        .done_o     (done),
        .rd_en_i    (rd_en),
        .rd_idx_i   (rd_idx),
        .rd_data_o  (rd_data),
        .rd_valid_o (rd_valid),
        .rd_err_o   (rd_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [3:0] idx, input logic err, input logic [127:0] data, input bit chk);
        exp_t e;
        e.err  = err;
        e.data = data;
        e.chk  = chk;
        sb.push_back(e);
        rd_en  = 1'b1;
        rd_idx = idx;
        tick();
        rd_en  = 1'b0;
    endtask

    task automatic run_expand(input int restart_at, input int flush_at);
        start = 1'b1;
        key   = {RK[14], RK[13]};
        tick();
        start = 1'b0;
        check("busy_e0", busy, 1);
        check("ready_e0", ready, 0);
        for (int k = 1; k <= 7; k++) begin
            if (k == restart_at) start = 1'b1;
            if (k == flush_at) flush = 1'b1;
            tick();
            start = 1'b0;
            flush = 1'b0;
            if (flush_at != 0 && k >= flush_at) begin
                check("busy_flushed", busy, 0);
                check("ready_flushed", ready, 0);
                check("done_flushed", done, 0);
            end else if (k < 7) begin
                check("busy_mid", busy, 1);
                check("ready_mid", ready, 0);
                check("done_mid", done, 0);
            end else begin
                check("busy_e7", busy, 0);
                check("ready_e7", ready, 1);
                check("done_e7", done, 1);
            end
        end
        tick();
        check("done_after", done, 0);
        check("ready_after", ready, (flush_at == 0) ? 1 : 0);
    endtask

    // Scoreboard monitor: every presented read result must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst && rd_valid) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_rd_valid: got rd_valid=1 expected no outstanding read");
            end else begin
                mon_e = sb.pop_front();
                check("rd_err", rd_err, mon_e.err);
                if (mon_e.chk) check("rd_data", rd_data, mon_e.data);
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_ready", ready, 0);
        check("rst_done", done, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_err", rd_err, 0);
        check("rst_rd_data", rd_data, 0);
        rst = 1'b0;
        tick();

        rd(4'd3, 1'b1, 128'h0, ZEROIZE);
        tick();

        run_expand(0, 0);
        rd(4'd14, 1'b0, RK[0], 1'b1);
        rd(4'd0, 1'b0, RK[14], 1'b1);
        for (int i = 0; i < 15; i++) rd(4'(i), 1'b0, RK[14-i], 1'b1);
        rd(4'd15, 1'b1, 128'h0, 1'b1);
        tick();

        run_expand(3, 0);
        rd(4'd7, 1'b0, RK[7], 1'b1);
        rd(4'd14, 1'b0, RK[0], 1'b1);
        tick();

        run_expand(0, 4);
        rd(4'd14, 1'b1, ZEROIZE ? 128'h0 : RK[0], 1'b1);
        rd(4'd2, 1'b1, ZEROIZE ? 128'h0 : RK[12], 1'b1);
        rd(4'd15, 1'b1, 128'h0, 1'b1);
        tick();

        start = 1'b1;
        flush = 1'b1;
        key   = {RK[14], RK[13]};
        tick();
        start = 1'b0;
        flush = 1'b0;
        check("flush_wins_busy", busy, 0);
        check("flush_wins_ready", ready, 0);
        tick();

        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rd(4'd5, 1'b1, ZEROIZE ? 128'h0 : RK[9], 1'b1);
        #6;
        check("busy_before_reset", busy, 1);
        rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_ready", ready, 0);
        check("arst_done", done, 0);
        check("arst_rd_valid", rd_valid, 0);
        check("arst_rd_err", rd_err, 0);
        check("arst_rd_data", rd_data, 0);
        tick();
        rst = 1'b0;
        tick();

        rd(4'd7, 1'b1, 128'h0, ZEROIZE);
        tick();
        run_expand(0, 0);
        for (int i = 0; i < 15; i++) rd(4'(i), 1'b0, RK[14-i], 1'b1);
        repeat (2) tick();
        check("scoreboard_drained", 128'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/aes256_inv_key_sched_ctrl.md
Name: aes256_inv_key_sched_ctrl

Overview:
- Sequential controller for AES-256 decryption round keys. Replaces the fully unrolled 7-stage inverse expansion with one shared inv_Key_Expansion step instance, iterated over 7 cycles.
- Results are held in a 15-entry x 128-bit round-key buffer, read by index from the decryption round engine.
- Sits between the key-load interface and the inverse-cipher round controller.

Parameters:
- NUM_RK, 15, number of stored 128-bit round keys (fixed for AES-256).
- NUM_STEPS, 7, number of inverse expansion steps.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to expand key; sampled only in IDLE or READY
- key  in  256  final 256 bits of the forward schedule (words 52..59), sampled with start
- flush  in  1  invalidate the stored schedule
- busy  out  1  expansion in progress
- ready  out  1  buffer holds a complete valid schedule
- done  out  1  one-cycle pulse when expansion completes
- rd_en  in  1  round-key read request
- rd_idx  in  4  round-key index, 0..14
- rd_data  out  128  registered read data
- rd_valid  out  1  rd_data valid, one cycle after rd_en
- rd_err  out  1  read was out of range or issued while not ready

Behaviour:
- Reset: state=IDLE; busy, ready, done, rd_valid, rd_err = 0; rd_data = 0; step counter = 0. Buffer contents are undefined after reset. Reset mid-expansion aborts immediately.
- FSM states: IDLE, EXPAND, READY.
- IDLE/READY with start=1 at edge E0:
  - work register <= key.
  - buf[0] <= key[255:128], buf[1] <= key[127:0].
  - Step counter s <= 1; ready <= 0; state <= EXPAND; busy <= 1.
- EXPAND, at each edge Es (s = 1..7):
  - Step instance input = work register, round index = 8-s, algorithm = 2'b10.
  - Step result R: work register <= R.
  - s = 1..6: buf[2s] <= R[255:128], buf[2s+1] <= R[127:0].
  - s = 7: buf[14] <= R[255:128] only; lower half discarded.
- At E7: state <= READY, busy <= 0, ready <= 1, done <= 1 for exactly one cycle.
- Latency: ready is high from 7 cycles after the start edge.
- start during EXPAND: ignored, no queueing.
- flush:
  - Any state: state <= IDLE, ready <= 0, busy <= 0, no done pulse.
  - flush and start in the same cycle: flush wins.
- Read port, evaluated at each edge where rd_en=1:
  - rd_valid <= 1.
  - rd_idx > 14: rd_err <= 1, rd_data <= 0.
  - rd_idx <= 14 and ready=0: rd_err <= 1, rd_data <= buf[rd_idx].
  - Otherwise: rd_err <= 0, rd_data <= buf[rd_idx].
  - Where rd_en=0: rd_valid <= 0, rd_err <= 0; rd_data holds its value.
- A read and a buffer write to the same entry at the same edge returns the old entry contents.

Optional Feature:
- Macro: AES_KEY_ZEROIZE_EN
- Defined:
  - flush additionally clears all 15 buffer entries and the work register to 0 in the same edge.
  - Reset also zeroes the buffer.
  - Not-ready reads return 0 (rd_err=1).
- Undefined: flush only clears state and ready; stale contents remain readable with rd_err=1.

Test Plan:
- Reset, then rd_en, rd_idx=3 -> rd_valid=1, rd_err=1; rd_data=0 with AES_KEY_ZEROIZE_EN.
- start with key = FIPS-197 C.3 schedule words 52..59 (key 000102..1f):
  - busy high for 7 cycles, done pulses once, ready=1.
  - rd_idx=14 -> 000102030405060708090a0b0c0d0e0f.
  - rd_idx=0 -> key[255:128].
- After ready, read indices 0..14 back-to-back -> each rd_data one cycle after request; all 15 entries match the unrolled golden model.
- start pulsed again at cycle 3 of EXPAND -> ignored; done occurs exactly 7 cycles after the first start.
- flush at cycle 4 of EXPAND -> ready stays 0, no done. Then rd_idx=14 -> rd_err=1; data 0 if zeroize is enabled, stale otherwise.
- Boundary reads:
  - rd_idx=15 -> rd_err=1, rd_data=0.
  - Assert reset mid-EXPAND -> all outputs 0 asynchronously.
  - Restart -> correct schedule.
